// File: rtl/pc_sequencer_pkg.sv
// Shared state encoding and PC constants for the PC sequencer.
// The optional trap path is enabled by defining PC_SEQ_TRAP_EN.
package pc_sequencer_pkg;

  localparam int              PC_W   = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer (master) and its consumer (slave).
// The trap request only exists when PC_SEQ_TRAP_EN is defined.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic            stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
`ifdef PC_SEQ_TRAP_EN
  logic            trap;
`endif
  logic            imem_ready;
  logic [PC_W-1:0] pc_out;
  logic            imem_req;
  logic            fetch_valid;
  logic            flush;
  logic [PC_W-1:0] fetch_cnt;

`ifdef PC_SEQ_TRAP_EN
  modport master (
    input  stall, br_taken, br_target, trap, imem_ready,
    output pc_out, imem_req, fetch_valid, flush, fetch_cnt
  );
  modport slave (
    output stall, br_taken, br_target, trap, imem_ready,
    input  pc_out, imem_req, fetch_valid, flush, fetch_cnt
  );
`else
  modport master (
    input  stall, br_taken, br_target, imem_ready,
    output pc_out, imem_req, fetch_valid, flush, fetch_cnt
  );
  modport slave (
    output stall, br_taken, br_target, imem_ready,
    input  pc_out, imem_req, fetch_valid, flush, fetch_cnt
  );
`endif

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// pc_next_sel: combinational next-PC priority selection (trap > branch > advance > hold).
// The trap leg is present only when PC_SEQ_TRAP_EN is defined.
module pc_next_sel import pc_sequencer_pkg::*; #(
  parameter logic [PC_W-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic            run,
`ifdef PC_SEQ_TRAP_EN
  input  logic            trap,
`endif
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            advance,
  input  logic [PC_W-1:0] pc_q,
  output logic [PC_W-1:0] pc_d,
  output logic            redirect
);

  // Redirect is kept apart from pc_d so it never depends on advance.
`ifdef PC_SEQ_TRAP_EN
  assign redirect = run & (trap | br_taken);
`else
  assign redirect = run & br_taken;
`endif

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d = pc_q;
`ifdef PC_SEQ_TRAP_EN
    if (run && trap) begin
      pc_d = TRAP_VECTOR;
    end else
`endif
    if (run && br_taken) begin
      pc_d = br_target & ~32'd3;
    end else if (advance) begin
      pc_d = pc_q + PC_INC;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: BOOT/FETCH/HOLD fetch FSM, PC register and completed-fetch counter.
// Define PC_SEQ_TRAP_EN to add the TRAP request and TRAP_VECTOR redirect.
module pc_sequencer import pc_sequencer_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_SEQ_TRAP_EN
  ,
  parameter logic [PC_W-1:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
  input logic            CLK,
  input logic            RST_N,
  pc_sequencer_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_cnt_q;
  logic            run, redirect, imem_req, fetch_valid;

  assign run = (state_q != BOOT);

  pc_next_sel #(
`ifdef PC_SEQ_TRAP_EN
    .TRAP_VECTOR (TRAP_VECTOR)
`endif
  ) u_next_sel (
    .run       (run),
`ifdef PC_SEQ_TRAP_EN
    .trap      (bus.trap),
`endif
    .br_taken  (bus.br_taken),
    .br_target (bus.br_target),
    .advance   (imem_req & bus.imem_ready),
    .pc_q      (pc_q),
    .pc_d      (pc_d),
    .redirect  (redirect)
  );

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      BOOT:  state_d = bus.stall ? HOLD : FETCH;
      FETCH: begin
        imem_req = ~bus.stall;
        if (redirect)       state_d = FETCH;
        else if (bus.stall) state_d = HOLD;
      end
      HOLD:    if (redirect || !bus.stall) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // A redirect wins over a completing fetch, so that fetch is not counted.
  assign fetch_valid = imem_req & bus.imem_ready & ~redirect;

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      fetch_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (fetch_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.imem_req    = imem_req;
  assign bus.fetch_valid = fetch_valid;
  assign bus.flush       = redirect;
  assign bus.fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; expected outputs are queued per step.
// Works with or without PC_SEQ_TRAP_EN defined.
module tb_pc_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        vld;
    logic        fl;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  o;
  } exp_t;

`ifdef PC_SEQ_TRAP_EN
  localparam logic [31:0] REDIR_PC = 32'h0000_0100;
`else
  localparam logic [31:0] REDIR_PC = 32'h0000_0040;
`endif

  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  pc_sequencer_if bus();

  pc_sequencer dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic req,
                            input logic vld, input logic fl, input logic [31:0] cnt);
    exp_t e;
    e.tag   = tag;
    e.o.pc  = pc;
    e.o.req = req;
    e.o.vld = vld;
    e.o.fl  = fl;
    e.o.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    obs_t obs;
    obs = {bus.pc_out, bus.imem_req, bus.fetch_valid, bus.flush, bus.fetch_cnt};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got pc=%h req=%b vld=%b fl=%b cnt=%h, required an expectation",
             obs.pc, obs.req, obs.vld, obs.fl, obs.cnt);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.o) else begin
        errors++;
        $error("FAIL %s: got pc=%h req=%b vld=%b fl=%b cnt=%h, required pc=%h req=%b vld=%b fl=%b cnt=%h",
               e.tag, obs.pc, obs.req, obs.vld, obs.fl, obs.cnt,
               e.o.pc, e.o.req, e.o.vld, e.o.fl, e.o.cnt);
      end
    end
  endtask

  // Entered just after a falling edge: drive, check settled outputs, then ride one full cycle.
  task automatic cyc(input string tag, input logic stall, input logic br, input logic [31:0] tgt,
                     input logic rdy, input logic [31:0] pc, input logic req, input logic vld,
                     input logic fl, input logic [31:0] cnt);
    bus.stall      = stall;
    bus.br_taken   = br;
    bus.br_target  = tgt;
    bus.imem_ready = rdy;
    expect_out(tag, pc, req, vld, fl, cnt);
    #1;
    check_now();
    @(negedge CLK);
  endtask

  initial begin
    RST_N          = 1'b0;
    bus.stall      = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_target  = 32'h0;
    bus.imem_ready = 1'b1;
`ifdef PC_SEQ_TRAP_EN
    bus.trap       = 1'b0;
`endif
    expect_out("reset_state", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    #7;
    check_now();
    @(negedge CLK);
    RST_N = 1'b1;

    // Boot then sequential fetch
    cyc("boot",        0, 0, 32'h0, 1, 32'h0000_0000, 0, 0, 0, 32'd0);
    cyc("fetch0",      0, 0, 32'h0, 1, 32'h0000_0000, 1, 1, 0, 32'd0);
    cyc("fetch4",      0, 0, 32'h0, 1, 32'h0000_0004, 1, 1, 0, 32'd1);
    cyc("fetch8",      0, 0, 32'h0, 1, 32'h0000_0008, 1, 1, 0, 32'd2);
    cyc("fetchC",      0, 0, 32'h0, 1, 32'h0000_000C, 1, 1, 0, 32'd3);
    // Memory not ready, then two stall cycles at 0x10
    cyc("not_ready",   0, 0, 32'h0, 0, 32'h0000_0010, 1, 0, 0, 32'd4);
    cyc("stall1",      1, 0, 32'h0, 1, 32'h0000_0010, 0, 0, 0, 32'd4);
    cyc("stall2",      1, 0, 32'h0, 1, 32'h0000_0010, 0, 0, 0, 32'd4);
    cyc("hold_exit",   0, 0, 32'h0, 1, 32'h0000_0010, 0, 0, 0, 32'd4);
    cyc("resume10",    0, 0, 32'h0, 1, 32'h0000_0010, 1, 1, 0, 32'd4);
    cyc("fetch14",     0, 0, 32'h0, 1, 32'h0000_0014, 1, 1, 0, 32'd5);
    cyc("fetch18",     0, 0, 32'h0, 1, 32'h0000_0018, 1, 1, 0, 32'd6);
    cyc("fetch1C",     0, 0, 32'h0, 1, 32'h0000_001C, 1, 1, 0, 32'd7);
    // Branch with simultaneous stall: target alignment and stall override
    cyc("br_stall",    1, 1, 32'h0000_0083, 1, 32'h0000_0020, 0, 0, 1, 32'd8);
    cyc("br_landed",   0, 0, 32'h0, 1, 32'h0000_0080, 1, 1, 0, 32'd8);
    // Redirect from HOLD to the top of the address space, then wrap
    cyc("to_hold",     1, 0, 32'h0, 1, 32'h0000_0084, 0, 0, 0, 32'd9);
    cyc("br_in_hold",  1, 1, 32'hFFFF_FFFE, 1, 32'h0000_0084, 0, 0, 1, 32'd9);
    cyc("fetch_top",   0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1, 1, 0, 32'd9);
    cyc("pc_wrap",     0, 0, 32'h0, 1, 32'h0000_0000, 1, 1, 0, 32'd10);
    // Redirects while memory stalls and while a fetch would complete
    cyc("br_not_rdy",  0, 1, 32'h0000_0200, 0, 32'h0000_0004, 1, 0, 1, 32'd11);
    cyc("br_rdy",      0, 1, 32'h0000_0300, 1, 32'h0000_0200, 1, 0, 1, 32'd11);
`ifdef PC_SEQ_TRAP_EN
    bus.trap = 1'b1;
    cyc("trap_and_br", 0, 1, 32'h0000_0040, 1, 32'h0000_0300, 1, 0, 1, 32'd11);
    bus.trap = 1'b0;
`else
    cyc("br_only",     0, 1, 32'h0000_0040, 1, 32'h0000_0300, 1, 0, 1, 32'd11);
`endif
    cyc("redir_land",  0, 0, 32'h0, 1, REDIR_PC, 1, 1, 0, 32'd11);

    // Counter wrap from a forced all-ones value
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    cyc("cnt_max",     0, 0, 32'h0, 1, REDIR_PC + 32'd4, 1, 1, 0, 32'hFFFF_FFFF);
    cyc("cnt_wrap",    0, 0, 32'h0, 1, REDIR_PC + 32'd8, 1, 1, 0, 32'd0);

    // Asynchronous reset mid-cycle with a pending fetch and redirect
    bus.stall      = 1'b0;
    bus.br_taken   = 1'b1;
    bus.br_target  = 32'h0000_0500;
    bus.imem_ready = 1'b0;
    expect_out("pending", REDIR_PC + 32'd12, 1'b1, 1'b0, 1'b1, 32'd1);
    #1;
    check_now();
    #1;
    RST_N = 1'b0;
    expect_out("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    check_now();
    @(negedge CLK);
    RST_N = 1'b1;

    // Restart; redirect during BOOT is ignored
    cyc("boot_br_ign", 0, 1, 32'h0000_0600, 1, 32'h0000_0000, 0, 0, 0, 32'd0);
    cyc("restart0",    0, 0, 32'h0, 1, 32'h0000_0000, 1, 1, 0, 32'd0);
    cyc("restart4",    0, 0, 32'h0, 1, 32'h0000_0004, 1, 1, 0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
